// File: rtl/rca_nibble_sequencer.sv
// Multi-word adder that streams wide operands through one 4-bit ripple-carry adder,
// one nibble per clock starting at the LSB, with the inter-nibble carry held in a register.

module rca (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic c;

    always_comb begin
        s = '0;
        c = c_in;
        for (int i = 0; i < 4; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        c_out = c;
    end
endmodule

module rca_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a_in,
    input  logic [4*NIBBLES-1:0] b_in,
    input  logic                 c_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 c_out,
    output logic                 busy
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [3:0]       nib_a, nib_b, rca_s;
    logic             rca_co;

    rca u_rca (
        .a     (nib_a),
        .b     (nib_b),
        .c_in  (carry_q),
        .s     (rca_s),
        .c_out (rca_co)
    );

    // Operand nibble mux driven only by registered state, never by a_in/b_in.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IDX_W'(n)) begin
                nib_a = a_q[4*n +: 4];
                nib_b = b_q[4*n +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IDX_W'(n)) sum_d[4*n +: 4] = rca_s;
                end
                if (idx_q == LAST) begin
                    cout_d  = rca_co;
                    state_d = DONE;
                end else begin
                    carry_d = rca_co;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Operand latches only need to be valid from accept onwards, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ADD) || (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = cout_q;
endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Directed bench for rca_nibble_sequencer with NIBBLES=4 (16-bit operands).

module tb_rca_nibble_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in, b_in;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    rca_nibble_sequencer #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands in IDLE, take the accept edge, then count edges until out_valid.
    task automatic start_and_wait(input logic [15:0] a, input logic [15:0] b, input logic c,
                                  output int lat);
        a_in = a; b_in = b; c_in = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0; c_in = 1'b0;
        tick(); tick();
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_valid_busy got=%b%b want=00", out_valid, busy);
        end
        total++;
        if (sum !== 16'h0000 || c_out !== 1'b0) begin
            bad++; $display("FAIL reset_result got=%h/%b want=0000/0", sum, c_out);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        start_and_wait(16'h0009, 16'h0006, 1'b0, lat);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL basic_latency got=%0d want=4", lat); end
        total++;
        if (sum !== 16'h000F || c_out !== 1'b0) begin
            bad++; $display("FAIL basic_sum got=%h/%b want=000f/0", sum, c_out);
        end
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL basic_done_flags busy=%b in_ready=%b want=1/0", busy, in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL basic_one_pulse out_valid=%b in_ready=%b want=0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_ripple();
        int lat;
        out_ready = 1'b1;
        start_and_wait(16'hFFFF, 16'h0001, 1'b0, lat);
        total++;
        if (sum !== 16'h0000 || c_out !== 1'b1 || lat !== 4) begin
            bad++; $display("FAIL ripple_ffff got=%h/%b lat=%0d want=0000/1 lat=4", sum, c_out, lat);
        end
        tick();
        start_and_wait(16'h7777, 16'h3333, 1'b1, lat);
        total++;
        if (sum !== 16'hAAAB || c_out !== 1'b0 || lat !== 4) begin
            bad++; $display("FAIL ripple_7777 got=%h/%b lat=%0d want=aaab/0 lat=4", sum, c_out, lat);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        start_and_wait(16'h0E0E, 16'h0606, 1'b0, lat);
        total++;
        if (sum !== 16'h1414 || c_out !== 1'b0 || lat !== 4) begin
            bad++; $display("FAIL bp_sum got=%h/%b lat=%0d want=1414/0 lat=4", sum, c_out, lat);
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                a_in = 16'h1111; b_in = 16'h2222; c_in = 1'b1; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h1414 || c_out !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got v=%b rdy=%b sum=%h co=%b want v=1 rdy=0 sum=1414 co=0",
                         i, out_valid, in_ready, sum, c_out);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        tick();
        total++;
        if (sum !== 16'h1414 || busy !== 1'b0) begin
            bad++; $display("FAIL bp_result_hold got sum=%h busy=%b want 1414/0", sum, busy);
        end
    endtask

    task automatic test_isolation();
        int lat;
        out_ready = 1'b1;
        a_in = 16'h1234; b_in = 16'h4321; c_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            a_in = 16'($urandom); b_in = 16'($urandom); c_in = 1'($urandom);
            tick();
            lat++;
        end
        total++;
        if (sum !== 16'h5555 || c_out !== 1'b0 || lat !== 4) begin
            bad++; $display("FAIL isolation got=%h/%b lat=%0d want=5555/0 lat=4", sum, c_out, lat);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        int lat;
        bit seen;
        out_ready = 1'b1;
        a_in = 16'h8888; b_in = 16'h8888; c_in = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL midop_rst_ready got=%b want=0", in_ready); end
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (sum !== 16'h0000 || c_out !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midop_abort got sum=%h co=%b v=%b rdy=%b want 0000/0/0/1",
                     sum, c_out, out_valid, in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL midop_no_valid got=1 want=0"); end
        start_and_wait(16'h0002, 16'h0005, 1'b1, lat);
        total++;
        if (sum !== 16'h0008 || c_out !== 1'b0 || lat !== 4) begin
            bad++; $display("FAIL midop_restart got=%h/%b lat=%0d want=0008/0 lat=4", sum, c_out, lat);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp_res;
        int cyc, last_acc, ops;
        bit have_last;
        out_ready = 1'b1;
        a_in = 16'($urandom); b_in = 16'($urandom); c_in = 1'($urandom);
        in_valid = 1'b1;
        cyc = 0; ops = 0; have_last = 1'b0; last_acc = 0; exp_res = '0;
        while (ops < 1000 && cyc < 20000) begin
            if (out_valid) begin
                total++;
                if ({c_out, sum} !== exp_res) begin
                    bad++;
                    $display("FAIL b2b_result op=%0d got=%b/%h want=%b/%h",
                             ops, c_out, sum, exp_res[16], exp_res[15:0]);
                end
                ops++;
            end
            if (in_ready) begin
                exp_res = {1'b0, a_in} + {1'b0, b_in} + {16'b0, c_in};
                if (have_last) begin
                    total++;
                    if (cyc - last_acc < 6) begin
                        bad++; $display("FAIL b2b_spacing got=%0d want>=6", cyc - last_acc);
                    end
                end
                have_last = 1'b1;
                last_acc = cyc;
            end
            tick();
            cyc++;
            a_in = 16'($urandom); b_in = 16'($urandom); c_in = 1'($urandom);
        end
        in_valid = 1'b0;
        total++;
        if (ops !== 1000) begin bad++; $display("FAIL b2b_count got=%0d want=1000", ops); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_backpressure();
        test_isolation();
        test_reset_midop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
